// File: rtl/req_encoder_16_4.sv
// 16:4 request encoder with valid/ready grant handshake and one-hot line acknowledge.
// Define REQ_ENC_ROUND_ROBIN_EN for round-robin selection; otherwise lowest index wins.
module req_encoder_16_4 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        ready,
  output logic        valid,
  output logic [3:0]  id,
  output logic [15:0] line_ack,
  output logic        dbg_state
);

  // Handshake: a grant transfers on any rising edge where valid && ready;
  // id is held stable while valid is high and valid only drops on transfer or rst.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t      r_state;
  logic        r_valid;
  logic [3:0]  r_id;
  logic        w_hs;
  logic [3:0]  w_sel;

`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [3:0]  r_ptr;
  logic [3:0]  w_idx;
  logic        w_found;

  // Scan upward from the pointer with natural 4-bit wrap from 15 to 0.
  always_comb begin
    w_sel   = r_ptr;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < 16; k++) begin
      w_idx = r_ptr + 4'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end
`else
  // Descending scan so the lowest set index is the last assignment.
  always_comb begin
    w_sel = '0;
    for (int k = 15; k >= 0; k--) begin
      if (req[k]) w_sel = 4'(k);
    end
  end
`endif

  assign w_hs = r_valid & ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_id    <= 4'h0;
`ifdef REQ_ENC_ROUND_ROBIN_EN
      r_ptr   <= 4'h0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_id    <= w_sel;
            r_valid <= 1'b1;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Request changes are ignored here; the IDLE bubble resamples req.
          if (w_hs) begin
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
`ifdef REQ_ENC_ROUND_ROBIN_EN
            r_ptr   <= r_id + 4'h1;
`endif
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign valid     = r_valid;
  assign id        = r_id;
  assign line_ack  = w_hs ? (16'h0001 << r_id) : 16'h0000;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_req_encoder_16_4.sv
// Directed self-checking bench for req_encoder_16_4; expectations follow
// REQ_ENC_ROUND_ROBIN_EN when it is defined for the build.
module tb_req_encoder_16_4;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        ready;
  logic        valid;
  logic [3:0]  id;
  logic [15:0] line_ack;
  logic        dbg_state;

  int n_cmp;
  int n_err;
  logic [3:0] exp_q[$];

  req_encoder_16_4 dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .ready     (ready),
    .valid     (valid),
    .id        (id),
    .line_ack  (line_ack),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, need finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, need %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req   = 16'h0000;
    ready = 1'b0;
    nxt();
    rst   = 1'b0;
  endtask

  task automatic check_grant(input string tag, input logic [3:0] exp_id);
    check({tag, "_valid"}, 16'(valid), 16'h0001);
    check({tag, "_state"}, 16'(dbg_state), 16'h0001);
    check({tag, "_id"}, 16'(id), 16'(exp_id));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 16'(valid), 16'h0000);
    check({tag, "_ack"}, line_ack, 16'h0000);
  endtask

  logic [3:0] e;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    req   = 16'hFFFF;
    ready = 1'b1;

    // Reset held for two edges with every request and ready high.
    for (int c = 0; c < 2; c++) begin
      nxt();
      check("rst_valid", 16'(valid), 16'h0000);
      check("rst_id", 16'(id), 16'h0000);
      check("rst_ack", line_ack, 16'h0000);
    end
    rst = 1'b0;
    nxt();
    check_grant("rst_first", 4'd0);
    check("rst_first_ack", line_ack, 16'h0001);
    req = 16'h0000;
    nxt();
    check_idle("rst_bubble");

    // Single request.
    do_reset();
    req   = 16'h0020;
    ready = 1'b1;
    nxt();
    check_grant("single", 4'd5);
    check("single_ack", line_ack, 16'h0020);
    req = 16'h0000;
    nxt();
    check_idle("single_after");

    // Fairness and wrap with two requesters held.
    do_reset();
    req   = 16'h8001;
    ready = 1'b1;
`ifdef REQ_ENC_ROUND_ROBIN_EN
    exp_q = '{4'd0, 4'd15, 4'd0, 4'd15};
`else
    exp_q = '{4'd0, 4'd0, 4'd0};
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nxt();
      check_grant("fair", e);
      check("fair_ack", line_ack, 16'h0001 << e);
      nxt();
      check_idle("fair_bubble");
    end

    // Backpressure: grant held while req changes and then drops.
    do_reset();
    req   = 16'h0008;
    ready = 1'b0;
    nxt();
    check_grant("bp_grant", 4'd3);
    check("bp_ack0", line_ack, 16'h0000);
    req = 16'h0002;
    nxt();
    check_grant("bp_hold1", 4'd3);
    check("bp_ack1", line_ack, 16'h0000);
    req = 16'h0000;
    nxt();
    check_grant("bp_hold2", 4'd3);
    check("bp_ack2", line_ack, 16'h0000);
    nxt();
    check_grant("bp_hold3", 4'd3);
    check("bp_ack3", line_ack, 16'h0000);
    ready = 1'b1;
    #1;
    check("bp_ack_hs", line_ack, 16'h0008);
    nxt();
    check_idle("bp_after1");
    nxt();
    check_idle("bp_after2");

    // Full load: every line requesting, ready held high.
    do_reset();
    req   = 16'hFFFF;
    ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
`ifdef REQ_ENC_ROUND_ROBIN_EN
      exp_q.push_back(4'(i % 16));
`else
      exp_q.push_back(4'd0);
`endif
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      nxt();
      check_grant("full", e);
      check("full_ack", line_ack, 16'h0001 << e);
      nxt();
      check_idle("full_bubble");
    end

    // Reset during a pending grant discards it without acknowledge.
    do_reset();
    req   = 16'h0080;
    ready = 1'b0;
    nxt();
    check_grant("mid_grant", 4'd7);
    check("mid_ack0", line_ack, 16'h0000);
    rst = 1'b1;
    #1;
    check("mid_ack_rst", line_ack, 16'h0000);
    nxt();
    check("mid_valid", 16'(valid), 16'h0000);
    check("mid_id", 16'(id), 16'h0000);
    check("mid_ack1", line_ack, 16'h0000);
    rst   = 1'b0;
    req   = 16'h0081;
    ready = 1'b1;
    nxt();
    check_grant("mid_regrant", 4'd0);
    check("mid_regrant_ack", line_ack, 16'h0001);

    // Ready while idle has no effect.
    req = 16'h0000;
    nxt();
    nxt();
    check_idle("idle_ready");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
